// File: rtl/prog_freq_divider_pkg.sv
// prog_freq_divider_pkg
//   Shared constants and types for the programmable tick divider:
//   the mode encodings, the RUN/HALT state type and the mode field width.
package prog_freq_divider_pkg;

   // Width of the mode field, kept as a function so every user derives it
   // from one place.
   function automatic int mode_width();
      return 2;
   endfunction

   localparam int MODE_W = mode_width();

   localparam logic [MODE_W-1:0] MODE_PULSE   = 2'd0;
   localparam logic [MODE_W-1:0] MODE_SQUARE  = 2'd1;
   localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'd2;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

endpackage

// File: rtl/prog_freq_divider_if.sv
// prog_freq_divider_if
//   Configuration request bus for the divider.
//   cfg_valid : request strobe (master -> slave)
//   div_in    : requested divisor (master -> slave)
//   mode_in   : requested mode (master -> slave)
//   cfg_ready : shadow register empty (slave -> master)
interface prog_freq_divider_if #(
   parameter int CNT_W = 9
);
   import prog_freq_divider_pkg::*;

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CNT_W-1:0]  div_in;
   logic [MODE_W-1:0] mode_in;

   modport master (output cfg_valid, output div_in, output mode_in, input cfg_ready);
   modport slave  (input cfg_valid, input div_in, input mode_in, output cfg_ready);

endinterface

// File: rtl/div_cfg_shadow.sv
// div_cfg_shadow
//   Captures configuration requests into a one-deep shadow and presents the
//   configuration that the next reload must use.
//   clk, rst  : clock, asynchronous active-high reset
//   cfg       : configuration bus (slave side, drives cfg_ready)
//   apply     : reload strobe from the counter; commits the effective config
//   eff_div   : divisor to load at a reload happening this cycle
//   eff_mode  : mode to adopt at a reload happening this cycle
module div_cfg_shadow
   import prog_freq_divider_pkg::*;
#(
   parameter int CNT_W    = 9,
   parameter int DIV_RST  = 511,
   parameter int MODE_RST = 0
) (
   input  logic                clk,
   input  logic                rst,
   prog_freq_divider_if.slave  cfg,
   input  logic                apply,
   output logic [CNT_W-1:0]    eff_div,
   output logic [MODE_W-1:0]   eff_mode
);

   logic               pending_r;
   logic [CNT_W-1:0]   sh_div_r;
   logic [MODE_W-1:0]  sh_mode_r;
   logic [CNT_W-1:0]   div_q_r;
   logic [MODE_W-1:0]  mode_q_r;
   logic               accept_s;

   assign accept_s      = cfg.cfg_valid & ~pending_r;
   assign cfg.cfg_ready = ~pending_r;

   // Effective config: a same-cycle request beats the shadow, which beats the active config.
   always_comb begin
      eff_div  = div_q_r;
      eff_mode = mode_q_r;
      if (accept_s) begin
         eff_div  = cfg.div_in;
         eff_mode = cfg.mode_in;
      end else if (pending_r) begin
         eff_div  = sh_div_r;
         eff_mode = sh_mode_r;
      end else begin
         eff_div  = div_q_r;
         eff_mode = mode_q_r;
      end
   end

   // Shadow capture, pending flag and commit of the effective config on reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= 1'b0;
         sh_div_r  <= {CNT_W{1'b0}};
         sh_mode_r <= MODE_PULSE;
         div_q_r   <= CNT_W'(DIV_RST);
         mode_q_r  <= MODE_W'(MODE_RST);
      end else if (apply) begin
         // A request accepted in this same cycle is consumed directly and
         // never parks in the shadow.
         div_q_r   <= eff_div;
         mode_q_r  <= eff_mode;
         pending_r <= 1'b0;
      end else if (accept_s) begin
         sh_div_r  <= cfg.div_in;
         sh_mode_r <= cfg.mode_in;
         pending_r <= 1'b1;
      end else begin
         pending_r <= pending_r;
      end
   end

endmodule

// File: rtl/prog_freq_divider.sv
// prog_freq_divider
//   Programmable clock-enable divider: one-cycle tick every DIV+1 enabled
//   cycles, 50% square output, or a single one-shot tick.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable (counter holds when low)
//   restart  : synchronous period restart, re-arms one-shot
//   cfg      : configuration bus (div_in, mode_in, cfg_valid, cfg_ready)
//   tick     : registered one-cycle terminal pulse
//   sq_out   : registered square output
//   busy     : high while counting, low once a one-shot has completed
//   cnt_out  : current down-counter value
module prog_freq_divider
   import prog_freq_divider_pkg::*;
#(
   parameter int CNT_W    = 9,
   parameter int DIV_RST  = 511,
   parameter int MODE_RST = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                restart,
   prog_freq_divider_if.slave  cfg,
   output logic                tick,
   output logic                sq_out,
   output logic                busy,
   output logic [CNT_W-1:0]    cnt_out
);

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               tick_r;
   logic               sq_r;
   logic               busy_r;
   logic               cnt_zero_s;
   logic               terminal_s;
   logic               reload_s;
   logic [CNT_W-1:0]   eff_div_s;
   logic [MODE_W-1:0]  eff_mode_s;

   div_cfg_shadow #(
      .CNT_W    (CNT_W),
      .DIV_RST  (DIV_RST),
      .MODE_RST (MODE_RST)
   ) u_shadow (
      .clk      (clk),
      .rst      (rst),
      .cfg      (cfg),
      .apply    (reload_s),
      .eff_div  (eff_div_s),
      .eff_mode (eff_mode_s)
   );

   // Reload points: restart, or an enabled terminal count while running.
   always_comb begin
      cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
      terminal_s = (state_r == ST_RUN) & en & cnt_zero_s;
      reload_s   = restart | terminal_s;
   end

   // Counter, RUN/HALT state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_W'(DIV_RST);
         tick_r  <= 1'b0;
         sq_r    <= 1'b0;
         busy_r  <= 1'b1;
      end else if (restart) begin
         state_r <= ST_RUN;
         cnt_r   <= eff_div_s;
         tick_r  <= 1'b0;
         sq_r    <= 1'b0;
         busy_r  <= 1'b1;
      end else if (terminal_s) begin
         tick_r <= 1'b1;
         cnt_r  <= eff_div_s;
         case (eff_mode_s)
            MODE_SQUARE: begin
               sq_r <= ~sq_r;
            end
            MODE_ONESHOT: begin
               sq_r    <= 1'b0;
               state_r <= ST_HALT;
               busy_r  <= 1'b0;
            end
            default: begin
               // PULSE and the reserved encoding behave identically.
               sq_r <= 1'b0;
            end
         endcase
      end else if (en && (state_r == ST_RUN)) begin
         cnt_r  <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         tick_r <= 1'b0;
      end else begin
         // Disabled or halted: everything holds except the tick pulse.
         tick_r <= 1'b0;
      end
   end

   assign tick    = tick_r;
   assign sq_out  = sq_r;
   assign busy    = busy_r;
   assign cnt_out = cnt_r;

endmodule

// File: tb/tb_prog_freq_divider.sv
// tb_prog_freq_divider
//   Directed, table-driven bench for prog_freq_divider with DIV_RST=3, PULSE.
module tb_prog_freq_divider;
   import prog_freq_divider_pkg::*;

   localparam int CNT_W = 9;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             restart;
   logic             tick;
   logic             sq_out;
   logic             busy;
   logic [CNT_W-1:0] cnt_out;

   int checks   = 0;
   int failures = 0;

   prog_freq_divider_if #(.CNT_W(CNT_W)) cfg_if ();

   prog_freq_divider #(
      .CNT_W    (CNT_W),
      .DIV_RST  (3),
      .MODE_RST (0)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .restart (restart),
      .cfg     (cfg_if.slave),
      .tick    (tick),
      .sq_out  (sq_out),
      .busy    (busy),
      .cnt_out (cnt_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             en;
      logic             restart;
      logic             cfg_valid;
      logic [CNT_W-1:0] div;
      logic [1:0]       mode;
      logic             e_tick;
      logic             e_sq;
      logic [CNT_W-1:0] e_cnt;
      logic             e_busy;
      logic             e_ready;
   } vec_t;

   vec_t vecs [0:31];
   int   n_vec = 0;

   task automatic add(input logic en_v, input logic rs_v, input logic cv_v,
                      input logic [CNT_W-1:0] d, input logic [1:0] m,
                      input logic et, input logic es, input logic [CNT_W-1:0] ec,
                      input logic eb, input logic er);
      vecs[n_vec] = '{en_v, rs_v, cv_v, d, m, et, es, ec, eb, er};
      n_vec++;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkn(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en_v, input logic rs_v, input logic cv_v,
                        input logic [CNT_W-1:0] d, input logic [1:0] m);
      en               = en_v;
      restart          = rs_v;
      cfg_if.cfg_valid = cv_v;
      cfg_if.div_in    = d;
      cfg_if.mode_in   = m;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks_seen;

      // Free-running PULSE, DIV=3: ticks after edges 4, 8, 12.
      for (int i = 1; i <= 12; i++) begin
         add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, (i % 4 == 0), 1'b0,
             CNT_W'((i % 4 == 0) ? 3 : 3 - (i % 4)), 1'b1, 1'b1);
      end
      // Park div=1 SQUARE in the shadow, then restart to apply it.
      add(1'b1, 1'b0, 1'b1, 9'd1, 2'd1, 1'b0, 1'b0, 9'd2, 1'b1, 1'b0);
      add(1'b1, 1'b1, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 9'd1, 1'b1, 1'b1);
      // SQUARE period 4: sq 0,1,1,0,0,1,1 on the following edges.
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1, 1'b1, 9'd1, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1, 1'b0, 9'd1, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1, 1'b1, 9'd1, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b1, 9'd0, 1'b1, 1'b1);
      // Request on the terminal cycle: used directly, shadow never fills, sq forced 0.
      add(1'b1, 1'b0, 1'b1, 9'd2, 2'd0, 1'b1, 1'b0, 9'd2, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 9'd1, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1);
      add(1'b1, 1'b0, 1'b0, 9'd0, 2'd0, 1'b1, 1'b0, 9'd2, 1'b1, 1'b1);

      drive(1'b0, 1'b0, 1'b0, 9'd0, 2'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chkn("rst_cnt", cnt_out, 9'd3);
      chk1("rst_tick", tick, 1'b0);
      chk1("rst_sq", sq_out, 1'b0);
      chk1("rst_busy", busy, 1'b1);
      chk1("rst_ready", cfg_if.cfg_ready, 1'b1);

      for (int i = 0; i < n_vec; i++) begin
         drive(vecs[i].en, vecs[i].restart, vecs[i].cfg_valid, vecs[i].div, vecs[i].mode);
         step();
         chkn($sformatf("vec%0d_cnt", i), cnt_out, vecs[i].e_cnt);
         chk1($sformatf("vec%0d_tick", i), tick, vecs[i].e_tick);
         chk1($sformatf("vec%0d_sq", i), sq_out, vecs[i].e_sq);
         chk1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         chk1($sformatf("vec%0d_ready", i), cfg_if.cfg_ready, vecs[i].e_ready);
      end

      // One-shot div=5 accepted while disabled, applied by restart.
      drive(1'b0, 1'b0, 1'b1, 9'd5, 2'd2);
      step();
      chkn("os_hold_cnt", cnt_out, 9'd2);
      chk1("os_pend_ready", cfg_if.cfg_ready, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 9'd0, 2'd0);
      step();
      chkn("os_restart_cnt", cnt_out, 9'd5);
      chk1("os_restart_ready", cfg_if.cfg_ready, 1'b1);
      for (int pass = 0; pass < 2; pass++) begin
         restart = 1'b0;
         for (int e = 1; e <= 6; e++) begin
            step();
            chk1($sformatf("os%0d_tick_e%0d", pass, e), tick, (e == 6));
         end
         chk1($sformatf("os%0d_busy", pass), busy, 1'b0);
         chkn($sformatf("os%0d_cnt", pass), cnt_out, 9'd5);
         ticks_seen = 0;
         for (int c = 0; c < 20; c++) begin
            step();
            if (tick === 1'b1) ticks_seen++;
         end
         chkn($sformatf("os%0d_quiet_ticks", pass), CNT_W'(ticks_seen), 9'd0);
         chk1($sformatf("os%0d_quiet_busy", pass), busy, 1'b0);
         restart = 1'b1;
         step();
         chk1($sformatf("os%0d_rearm_busy", pass), busy, 1'b1);
         chkn($sformatf("os%0d_rearm_cnt", pass), cnt_out, 9'd5);
      end
      // Leave the one-shot to expire (last rearm above), then halted.
      restart = 1'b0;
      repeat (6) step();
      chk1("os_final_busy", busy, 1'b0);

      // div=7 PULSE parked while halted, applied only by restart.
      drive(1'b1, 1'b0, 1'b1, 9'd7, 2'd0);
      step();
      chk1("halt_pend_ready", cfg_if.cfg_ready, 1'b0);
      chkn("halt_hold_cnt", cnt_out, 9'd5);
      drive(1'b1, 1'b1, 1'b0, 9'd0, 2'd0);
      step();
      chkn("d7_restart_cnt", cnt_out, 9'd7);
      chk1("d7_busy", busy, 1'b1);
      restart = 1'b0;
      // div=2 accepted mid-period at cnt_out=4: ticks at edges 8, 11, 14.
      for (int e = 1; e <= 14; e++) begin
         if (e == 4) begin
            chkn("mid_acc_cnt", cnt_out, 9'd4);
            drive(1'b1, 1'b0, 1'b1, 9'd2, 2'd0);
         end else begin
            drive(1'b1, 1'b0, 1'b0, 9'd0, 2'd0);
         end
         step();
         chk1($sformatf("mid_tick_e%0d", e), tick, (e == 8 || e == 11 || e == 14));
         if (e == 4 || e == 7) chk1($sformatf("mid_ready_e%0d", e), cfg_if.cfg_ready, 1'b0);
         if (e == 8) chk1("mid_ready_after", cfg_if.cfg_ready, 1'b1);
      end

      // Enable low for 5 cycles at cnt_out=2 stretches the period by 5.
      en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chkn($sformatf("stall_cnt%0d", c), cnt_out, 9'd2);
         chk1($sformatf("stall_tick%0d", c), tick, 1'b0);
      end
      en = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         step();
         chk1($sformatf("resume_tick_e%0d", e), tick, (e == 3));
      end

      // Reset mid-count with a pending div=6 SQUARE request.
      drive(1'b1, 1'b0, 1'b1, 9'd6, 2'd1);
      step();
      chk1("pre_rst_ready", cfg_if.cfg_ready, 1'b0);
      cfg_if.cfg_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chkn("arst_cnt", cnt_out, 9'd3);
      chk1("arst_ready", cfg_if.cfg_ready, 1'b1);
      chk1("arst_busy", busy, 1'b1);
      chk1("arst_tick", tick, 1'b0);
      chk1("arst_sq", sq_out, 1'b0);
      #2 rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         step();
         chk1($sformatf("post_rst_tick_e%0d", e), tick, (e == 4));
         chk1($sformatf("post_rst_sq_e%0d", e), sq_out, 1'b0);
      end
      chkn("post_rst_reload", cnt_out, 9'd3);

      // DIV=0 PULSE via same-cycle request on restart: tick stays high.
      drive(1'b1, 1'b1, 1'b1, 9'd0, 2'd0);
      step();
      chkn("d0_cnt", cnt_out, 9'd0);
      chk1("d0_ready", cfg_if.cfg_ready, 1'b1);
      chk1("d0_tick0", tick, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 9'd0, 2'd0);
      for (int e = 1; e <= 3; e++) begin
         step();
         chk1($sformatf("d0_tick_e%0d", e), tick, 1'b1);
         chkn($sformatf("d0_cnt_e%0d", e), cnt_out, 9'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prog_freq_divider.md
Name: prog_freq_divider

Overview:
Programmable, parametrised clock-enable divider. It generates a one-cycle tick every DIV+1 enabled cycles, a 50%-duty square output, or a single one-shot tick. The divisor and mode are reconfigured through a valid/ready handshake into a shadow register, so a change never truncates a period. It sits between the user switch/config logic and the timing consumers (blinkers, display scanners, UART baud enables) as the single tick source.

Parameters:
CNT_W, 9, counter and divisor width; the tick period is DIV+1 cycles, with DIV in 0..2^CNT_W-1.
DIV_RST, 511, active divisor and counter value at reset.
MODE_RST, 0, active mode at reset (0 PULSE).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; when low the counter holds
restart  in  1  synchronous restart of the period; re-arms one-shot
div_in  in  CNT_W  requested divisor
mode_in  in  2  requested mode: 0 PULSE, 1 SQUARE, 2 ONESHOT, 3 reserved (treated as PULSE)
cfg_valid  in  1  config request
cfg_ready  out  1  shadow empty; a config is accepted when cfg_valid and cfg_ready are both high
tick  out  1  registered, one-cycle terminal pulse
sq_out  out  1  registered square output
busy  out  1  high in RUN, low in HALT
cnt_out  out  CNT_W  current down-counter value

Behaviour:
- Reset is asynchronous, active-high, on rst, clocked by clk. Reset values:
  - cnt = DIV_RST, div_q = DIV_RST, mode_q = MODE_RST
  - pending = 0, state = RUN
  - tick = 0, sq_out = 0, cfg_ready = 1, busy = 1
- States:
  - RUN: counting.
  - HALT: one-shot complete; the counter holds and tick stays 0.
- cfg_ready = !pending.
- On accept, div_in/mode_in go to the shadow and pending is set to 1.
- The effective config at a reload is:
  - the config accepted in the same cycle, if any;
  - else the shadow, if pending;
  - else div_q/mode_q.
  Applying a shadow or same-cycle config updates div_q/mode_q and clears pending.
- Edge priority: rst > restart > en.
- restart:
  - cnt <= effective div; state <= RUN; tick <= 0; sq_out <= 0.
  - The effective config is applied.
- RUN, en=1, cnt != 0: cnt <= cnt-1; tick <= 0.
- RUN, en=1, cnt == 0 (terminal):
  - tick <= 1.
  - cnt <= effective div, and the effective config is applied.
  - SQUARE: sq_out toggles, giving period 2*(DIV+1) and 50% duty.
  - ONESHOT: state <= HALT.
  - PULSE/reserved: sq_out <= 0.
- en=0: cnt, state and sq_out hold; tick <= 0. A config may still be accepted; it waits in the shadow.
- HALT: tick = 0. A pending config is applied only by restart.
- Latency: the first tick is asserted DIV_RST+1 enabled edges after reset release or restart (DIV+1 edges after restart).
- DIV=0 in PULSE gives tick continuously high while en=1.
- A mode change takes effect only at a reload point (terminal count or restart). On the switch sq_out is forced to 0 unless the new mode is SQUARE, in which case it toggles normally.
- The counter never wraps: it reloads at 0. No arithmetic overflow is possible.
- rst asserted mid-period: all state returns to the reset values immediately; the shadow is discarded.

Decomposition:
- Package prog_freq_divider_pkg holds:
  - the mode constants MODE_PULSE=0, MODE_SQUARE=1, MODE_ONESHOT=2;
  - the state encoding RUN/HALT;
  - a function for the mode width (2).
- One sub-module, div_cfg_shadow, handles the valid/ready capture, the pending flag and the apply strobe, and outputs the effective div/mode.
- Counter, FSM and output registers stay in the top level.

Test Plan:
- Reset with DIV_RST=3, PULSE, en=1 -> tick high after edges 4, 8 and 12 after reset release; cnt_out sequence 3,2,1,0,3.
- Config div=1 mode=SQUARE, then restart -> sq_out reads 0,0,1,1,0,0,1,1 in the cycles after restart (period 4); tick every 2 cycles.
- Config div=5 ONESHOT, then restart -> exactly one tick 6 edges after restart, then busy=0 with no further ticks for 20 cycles; a second restart gives one more tick.
- Running div=7; config div=2 accepted at cnt_out=4 -> cfg_ready=0 until the terminal; tick intervals are 8 then 3, 3; cfg_ready returns to 1 after the terminal.
- Config handshake in the same cycle as a terminal count -> the new div is used for that reload directly; pending never set.
- en low for 5 cycles at cnt_out=2 -> cnt holds and tick=0; the period is stretched by 5.
- rst pulsed mid-count with a pending shadow -> outputs return to reset values and the shadow is discarded.
